ps_linebuffer_ctrl: RTL and testbench

//  Sequences four 3-tap line buffers into a streaming 3x3 window generator.

---
 rtl/ps_linebuffer_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_ps_linebuffer_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_linebuffer_ctrl.sv
// ps_linebuffer_ctrl: rotates four line buffers and
// reads three rows in lockstep to build 3x3 windows.
module ps_linebuffer_ctrl #(
  parameter int LINE_LENGTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int DATA_WIDTH   = 1,
  parameter int CLAMP_EDGES  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [3:0]              o_wr,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [3:0]              o_rd,
  input  logic [12*DATA_WIDTH-1:0] i_rdata,
  output logic                    o_valid,
  output logic [9*DATA_WIDTH-1:0] o_window,
  output logic                    o_sol,
  output logic                    o_eof
);

  localparam int L  = LINE_LENGTH;
  localparam int H  = FRAME_HEIGHT;
  localparam int DW = DATA_WIDTH;
  localparam int TW = 3 * DW;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int RW = $clog2(H + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(L - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [RW:0]   ROW_H    = (RW + 1)'(H);

  typedef enum logic [1:0] {
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_flush;
  logic [CW-1:0] r_wr_col;
  logic [RW-1:0] r_wr_row;
  logic [CW-1:0] r_rd_col;
  logic [RW-1:0] r_rd_row;

  logic          r_p1_valid;
  logic          r_p1_sol;
  logic          r_p1_eof;
  logic [RW-1:0] r_p1_row;

  logic          r_valid;
  logic          r_sol;
  logic          r_eof;
  logic [9*DW-1:0] r_window;

  logic [RW:0]   w_wr_row_x;
  logic [RW:0]   w_rd_plus2;
  logic [RW:0]   w_need;
  logic          w_ready;
  logic          w_xfer;
  logic          w_frame_end;
  logic          w_reading;
  logic          w_rd_first;
  logic          w_rd_last;
  logic [1:0]    w_top_b;
  logic [1:0]    w_mid_b;
  logic [1:0]    w_bot_b;

  logic [TW-1:0] w_tap [4];
  logic [1:0]    w_p1_mid_b;
  logic [1:0]    w_p1_top_b;
  logic [1:0]    w_p1_bot_b;
  logic [TW-1:0] w_top;
  logic [TW-1:0] w_mid;
  logic [TW-1:0] w_bot;

  function automatic logic [3:0] f_onehot(
    input logic [1:0] b
  );
    return 4'b0001 << b;
  endfunction

  assign w_wr_row_x = {1'b0, r_wr_row};
  assign w_rd_plus2 = {1'b0, r_rd_row} + (RW + 1)'(2);
  assign w_need     = (w_rd_plus2 > ROW_H) ? ROW_H
                                           : w_rd_plus2;

  // the buffer holding row rd_row-1 is never refilled
  // until that row has been consumed
  assign w_ready = i_rstn
                 & (w_wr_row_x < ROW_H)
                 & (w_wr_row_x <= w_rd_plus2);
  assign w_xfer  = i_valid & w_ready;

  assign w_frame_end = (r_state == S_DONE) & r_flush;

  assign o_ready = w_ready;
  assign o_wdata = i_data;
  assign o_wr    = w_xfer ? f_onehot(r_wr_row[1:0])
                          : 4'b0000;

  assign w_rd_first = (r_rd_row == '0);
  assign w_rd_last  = (r_rd_row == ROW_LAST);
  assign w_mid_b    = r_rd_row[1:0];
  assign w_top_b    = w_rd_first ? w_mid_b
                                 : w_mid_b - 2'd1;
  assign w_bot_b    = w_rd_last ? w_mid_b
                                : w_mid_b + 2'd1;

  assign w_reading = i_rstn & (r_state == S_READ);
  assign o_rd = w_reading ? (f_onehot(w_top_b)
                          | f_onehot(w_mid_b)
                          | f_onehot(w_bot_b))
                          : 4'b0000;

  // write-side column/row counters
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wr_col <= '0;
      r_wr_row <= '0;
    end else if (w_frame_end) begin
      r_wr_col <= '0;
      r_wr_row <= '0;
    end else if (w_xfer) begin
      if (r_wr_col == COL_LAST) begin
        r_wr_col <= '0;
        r_wr_row <= r_wr_row + 1'b1;
      end else begin
        r_wr_col <= r_wr_col + 1'b1;
      end
    end
  end

  // read sequencer: wait for row r+1, sweep a row, flush
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state  <= S_WAIT;
      r_flush  <= 1'b0;
      r_rd_col <= '0;
      r_rd_row <= '0;
    end else begin
      unique case (r_state)
        S_WAIT: begin
          r_rd_col <= '0;
          if (w_wr_row_x >= w_need)
            r_state <= S_READ;
        end
        S_READ: begin
          if (r_rd_col == COL_LAST) begin
            r_rd_col <= '0;
            r_rd_row <= r_rd_row + 1'b1;
            r_flush  <= 1'b0;
            r_state  <= w_rd_last ? S_DONE : S_WAIT;
          end else begin
            r_rd_col <= r_rd_col + 1'b1;
          end
        end
        S_DONE: begin
          if (r_flush) begin
            r_flush  <= 1'b0;
            r_rd_row <= '0;
            r_state  <= S_WAIT;
          end else begin
            r_flush <= 1'b1;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // stage 1: row index and flags follow the buffer read
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_p1_valid <= 1'b0;
      r_p1_sol   <= 1'b0;
      r_p1_eof   <= 1'b0;
      r_p1_row   <= '0;
    end else begin
      r_p1_valid <= w_reading;
      r_p1_row   <= r_rd_row;
      r_p1_sol   <= w_reading & (r_rd_col == '0);
      r_p1_eof   <= w_reading & w_rd_last
                  & (r_rd_col == COL_LAST);
    end
  end

  // split the tap bus into per-buffer groups
  always_comb begin
    for (int b = 0; b < 4; b++)
      w_tap[b] = i_rdata[b*TW +: TW];
  end

  assign w_p1_mid_b = r_p1_row[1:0];
  assign w_p1_top_b = w_p1_mid_b - 2'd1;
  assign w_p1_bot_b = w_p1_mid_b + 2'd1;

  // vertical edge handling at the first and last rows
  always_comb begin
    w_mid = w_tap[w_p1_mid_b];
    w_top = w_tap[w_p1_top_b];
    w_bot = w_tap[w_p1_bot_b];
    if (r_p1_row == '0)
      w_top = (CLAMP_EDGES != 0) ? w_mid : '0;
    if (r_p1_row == ROW_LAST)
      w_bot = (CLAMP_EDGES != 0) ? w_mid : '0;
  end

  // stage 2: registered window and qualifiers
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_valid  <= 1'b0;
      r_sol    <= 1'b0;
      r_eof    <= 1'b0;
      r_window <= '0;
    end else begin
      r_valid <= r_p1_valid;
      r_sol   <= r_p1_sol;
      r_eof   <= r_p1_eof;
      if (r_p1_valid)
        r_window <= {w_top, w_mid, w_bot};
    end
  end

  // in-flight windows vanish as soon as reset asserts
  assign o_valid  = r_valid & i_rstn;
  assign o_sol    = r_valid & r_sol & i_rstn;
  assign o_eof    = r_valid & r_eof & i_rstn;
  assign o_window = r_window;

endmodule

// File: tb/tb_ps_linebuffer_ctrl.sv
// tb_ps_linebuffer_ctrl: directed frames through a
// clamped and a zero-fill controller with buffer models.
module tb_ps_linebuffer_ctrl;

  localparam int L  = 8;
  localparam int H  = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] din = '0;

  logic        rdy   [2];
  logic [3:0]  wr    [2];
  logic [3:0]  rd    [2];
  logic [7:0]  wdata [2];
  logic [95:0] rdata [2];
  logic        ov    [2];
  logic [71:0] win   [2];
  logic        sol   [2];
  logic        eof   [2];

  always #5 clk = ~clk;

  ps_linebuffer_ctrl #(
    .LINE_LENGTH(L), .FRAME_HEIGHT(H),
    .DATA_WIDTH(DW), .CLAMP_EDGES(1)
  ) u_clamp (
    .i_clk(clk), .i_rstn(rstn), .i_valid(vld),
    .o_ready(rdy[0]), .i_data(din), .o_wr(wr[0]),
    .o_wdata(wdata[0]), .o_rd(rd[0]),
    .i_rdata(rdata[0]), .o_valid(ov[0]),
    .o_window(win[0]), .o_sol(sol[0]),
    .o_eof(eof[0])
  );

  ps_linebuffer_ctrl #(
    .LINE_LENGTH(L), .FRAME_HEIGHT(H),
    .DATA_WIDTH(DW), .CLAMP_EDGES(0)
  ) u_zero (
    .i_clk(clk), .i_rstn(rstn), .i_valid(vld),
    .o_ready(rdy[1]), .i_data(din), .o_wr(wr[1]),
    .o_wdata(wdata[1]), .o_rd(rd[1]),
    .i_rdata(rdata[1]), .o_valid(ov[1]),
    .o_window(win[1]), .o_sol(sol[1]),
    .o_eof(eof[1])
  );

  // line buffer models: edge taps replicate the end pixel
  logic [7:0] mem [2][4][L];
  int wp [2][4];
  int rp [2][4];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (!rstn) begin
          wp[k][b] <= 0;
          rp[k][b] <= 0;
        end else begin
          if (wr[k][b]) begin
            mem[k][b][wp[k][b]] <= wdata[k];
            wp[k][b] <= (wp[k][b] == L-1) ? 0
                                          : wp[k][b] + 1;
          end
          if (rd[k][b]) begin
            rdata[k][b*24 +: 24] <= {
              mem[k][b][(rp[k][b] == 0) ? 0
                                        : rp[k][b] - 1],
              mem[k][b][rp[k][b]],
              mem[k][b][(rp[k][b] == L-1) ? L-1
                                          : rp[k][b] + 1]};
            rp[k][b] <= (rp[k][b] == L-1) ? 0
                                          : rp[k][b] + 1;
          end
        end
      end
    end
  end

  typedef struct packed {
    logic [71:0] w;
    logic        s;
    logic        e;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   rd_cyc = 0;
  int   ovl = 0;
  int   eof_rdy = 0;

  // capture windows and watch read/write overlap
  always @(negedge clk) begin
    if (ov[0]) begin
      q0.push_back({win[0], sol[0], eof[0]});
      if (eof[0] && rdy[0]) eof_rdy++;
    end
    if (ov[1]) q1.push_back({win[1], sol[1], eof[1]});
    if (|rd[0]) rd_cyc++;
    if ((wr[0] & rd[0]) != 4'b0000) ovl++;
  end

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string tag,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] px(int base, int r,
                                    int c);
    return 8'(base + r*16 + c);
  endfunction

  function automatic logic [23:0] taps(int base, int r,
                                       int c);
    return {px(base, r, (c == 0) ? 0 : c-1),
            px(base, r, c),
            px(base, r, (c == L-1) ? L-1 : c+1)};
  endfunction

  function automatic logic [71:0] exp_win(int base,
      int r, int c, bit clamp);
    logic [23:0] t, m, b;
    m = taps(base, r, c);
    t = (r == 0) ? (clamp ? m : 24'h0)
                 : taps(base, r-1, c);
    b = (r == H-1) ? (clamp ? m : 24'h0)
                   : taps(base, r+1, c);
    return {t, m, b};
  endfunction

  int tmo = 0;

  task automatic push(input logic [7:0] d);
    int  n = 0;
    bit  ok = 0;
    vld = 1'b1;
    din = d;
    do begin
      @(negedge clk);
      ok = rdy[0];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    vld = 1'b0;
    if (!ok) tmo++;
  endtask

  task automatic send(input int base, input bit gaps,
                      input int npix);
    for (int i = 0; i < npix; i++) begin
      if (tmo != 0) break;
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      push(px(base, i / L, i % L));
    end
  endtask

  task automatic drain(input string tag, input int n);
    int k = 0;
    while ((q0.size() < n || q1.size() < n)
           && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({tag, "_cnt0"}, 72'(q0.size()), 72'(n));
    chk({tag, "_cnt1"}, 72'(q1.size()), 72'(n));
  endtask

  task automatic check_frame(input string tag,
                             input int off,
                             input int base);
    for (int i = 0; i < L*H; i++) begin
      int r, c;
      r = i / L;
      c = i % L;
      if (off + i < q0.size()) begin
        chk($sformatf("%s_c%0d_%0d", tag, r, c),
            q0[off+i].w, exp_win(base, r, c, 1'b1));
        chk($sformatf("%s_f%0d_%0d", tag, r, c),
            72'({q0[off+i].s, q0[off+i].e}),
            72'({c == 0, (r == H-1) && (c == L-1)}));
      end
      if (off + i < q1.size())
        chk($sformatf("%s_z%0d_%0d", tag, r, c),
            q1[off+i].w, exp_win(base, r, c, 1'b0));
    end
  endtask

  int rd0, ovl0, eofr0;
  logic [71:0] w;

  initial begin
    rstn = 1'b0;
    vld  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 72'(rdy[0]), 72'(0));
    chk("rst_valid", 72'(ov[0]), 72'(0));
    chk("rst_win", win[0], 72'(0));
    chk("rst_wr", 72'(wr[0]), 72'(0));
    chk("rst_rd", 72'(rd[0]), 72'(0));
    @(posedge clk);
    #1;
    vld  = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_up", 72'(rdy[0]), 72'(1));
    @(posedge clk);
    #1;

    // frame with i_valid held high
    rd0 = rd_cyc; ovl0 = ovl; eofr0 = eof_rdy;
    send(0, 1'b0, L*H);
    @(negedge clk);
    chk("ready_lastrow", 72'(rdy[0]), 72'(0));
    drain("f1", L*H);
    check_frame("f1", 0, 0);
    if (q0.size() == L*H && q1.size() == L*H) begin
      w = q0[3].w;
      chk("w03_mid", 72'(w[39:32]), 72'(8'h03));
      chk("w03_top", 72'(w[63:56]), 72'(8'h03));
      chk("w03_bot", 72'(w[15:8]), 72'(8'h13));
      w = q0[21].w;
      chk("w25_mid", 72'(w[39:32]), 72'(8'h25));
      chk("w25_top", 72'(w[63:56]), 72'(8'h15));
      chk("w25_bot", 72'(w[15:8]), 72'(8'h35));
      w = q0[28].w;
      chk("w34_bot", 72'(w[15:8]), 72'(8'h34));
      w = q1[2].w;
      chk("z02_top", 72'(w[71:48]), 72'(0));
      w = q1[30].w;
      chk("z36_bot", 72'(w[23:0]), 72'(0));
    end
    chk("eof_ready", 72'(eof_rdy - eofr0), 72'(0));
    chk("rd_cycles", 72'(rd_cyc - rd0), 72'(L*H));
    chk("wr_rd_ovl", 72'(ovl - ovl0), 72'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_next", 72'(rdy[0]), 72'(1));
    chk("tmo_f1", 72'(tmo), 72'(0));
    q0.delete(); q1.delete();
    @(posedge clk);
    #1;

    // frame with random input gaps
    rd0 = rd_cyc; ovl0 = ovl;
    send(0, 1'b1, L*H);
    drain("f2", L*H);
    check_frame("f2", 0, 0);
    chk("rd_cyc_gap", 72'(rd_cyc - rd0), 72'(L*H));
    chk("ovl_gap", 72'(ovl - ovl0), 72'(0));
    chk("tmo_f2", 72'(tmo), 72'(0));
    repeat (4) @(posedge clk);
    #1;
    q0.delete(); q1.delete();

    // reset in the middle of row 2
    send(0, 1'b0, 2*L + 4);
    rstn = 1'b0;
    vld  = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 72'(ov[0]), 72'(0));
    chk("mid_rst_ready", 72'(rdy[0]), 72'(0));
    chk("mid_rst_wr", 72'(wr[0]), 72'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    vld  = 1'b0;
    q0.delete(); q1.delete();
    chk("mid_rst_win", win[0], 72'(0));
    send(0, 1'b0, L*H);
    drain("f3", L*H);
    check_frame("f3", 0, 0);
    chk("tmo_f3", 72'(tmo), 72'(0));
    repeat (4) @(posedge clk);
    #1;
    q0.delete(); q1.delete();

    // back-to-back frames with distinct data
    send(0, 1'b0, L*H);
    send(8'h80, 1'b0, L*H);
    drain("f45", 2*L*H);
    check_frame("f4", 0, 0);
    check_frame("f5", L*H, 8'h80);
    if (q0.size() == 2*L*H) begin
      w = q0[L*H + 2].w;
      chk("f5_top", 72'(w[63:56]), 72'(8'h82));
      chk("f5_mid", 72'(w[39:32]), 72'(8'h82));
    end
    chk("tmo_f45", 72'(tmo), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
